// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM encoding, parity sense and prescale floor.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int                    PRESCALE_W   = 5;
  localparam logic [PRESCALE_W-1:0] PRESCALE_MIN = 5'd4;

  function automatic logic [PRESCALE_W-1:0] clamp_prescale(input logic [PRESCALE_W-1:0] ps);
    return (ps < PRESCALE_MIN) ? PRESCALE_MIN : ps;
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: edge counter 0..prescale-1, bit counter bumps on each wrap.
// Zero latency on bit_done; both counters clear whenever en is low.
module tx_bit_timer
  import uart_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  bit_done,
  output logic [CNT_W-1:0]      bit_cnt
);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;

  assign bit_done = en && (edge_cnt_q == (prescale - PRESCALE_W'(1)));
  assign bit_cnt  = bit_cnt_q;

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (!en) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (bit_done) begin
      edge_cnt_d = '0;
      bit_cnt_d  = bit_cnt_q + CNT_W'(1);
    end else begin
      edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity, one stop; TX_OUT/busy registered.
// Frame starts the cycle after an accepted Data_Valid; requests while busy are dropped, not queued.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  // Frame bit index: 0 = start, 1..DATA_WIDTH = data, then parity/stop.
  localparam int               CNT_W     = $clog2(DATA_WIDTH + 4);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_bit_q, par_bit_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic                  bit_done;
  logic [CNT_W-1:0]      bit_cnt;

  tx_bit_timer #(
    .CNT_W (CNT_W)
  ) u_bit_timer (
    .CLK      (CLK),
    .RST      (RST),
    .en       (state_q != ST_IDLE),
    .prescale (prescale_q),
    .bit_done (bit_done),
    .bit_cnt  (bit_cnt)
  );

  // tx_d is the level for the upcoming bit, so TX_OUT lines up with state changes.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_bit_d  = par_bit_q;
    prescale_d = prescale_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (Data_Valid) begin
          data_d     = P_DATA;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_bit_d  = (^P_DATA) ^ (PAR_TYP == PAR_ODD);
          prescale_d = clamp_prescale(Prescale);
          state_d    = ST_START;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_d = ST_DATA;
          tx_d    = data_q[0];
          data_d  = data_q >> 1;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_cnt == LAST_DATA) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
            tx_d    = par_en_q ? par_bit_q : 1'b1;
          end else begin
            tx_d   = data_q[0];
            data_d = data_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bit_q  <= 1'b0;
      prescale_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_bit_q  <= par_bit_d;
      prescale_q <= prescale_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that mirrors the existing UART receive path. It accepts a parallel word with a valid strobe and serialises it onto `TX_OUT` as a frame: start bit, data LSB first, optional parity bit, one stop bit. Each bit lasts `Prescale` clock cycles, so the same clock and prescale setting drive both ends of the link. It sits between the system-side register/FIFO logic and the UART pin.

## Interface
- `DATA_WIDTH`, default 8: number of data bits per frame.
- `CLK`  input  1  block clock; all state updates on rising edge.
- `RST`  input  1  reset; one clock, asynchronous assert, active-low.
- `P_DATA`  input  DATA_WIDTH  parallel word to transmit.
- `Data_Valid`  input  1  request to send `P_DATA`; sampled only while `busy`=0.
- `PAR_EN`  input  1  1 = insert parity bit.
- `PAR_TYP`  input  1  0 = even parity, 1 = odd parity.
- `Prescale`  input  5  clock cycles per bit; legal values 4..31.
- `TX_OUT`  output  1  serial line; idles high.
- `busy`  output  1  high while a frame is in progress.

## Operation
- Reset values: `TX_OUT`=1, `busy`=0, FSM=IDLE, counters 0, shadow registers 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `TX_OUT`=1. If `Data_Valid`=1 at a rising edge, the block captures `P_DATA`, `PAR_EN`, `PAR_TYP` and `Prescale` into shadow registers. It also captures the parity bit, computed as XOR of the data XOR `PAR_TYP`. It then moves to START.
- START lasts 1 bit time with `TX_OUT`=0, then goes to DATA.
- DATA lasts DATA_WIDTH bit times and sends bit 0 first.
- After DATA, the FSM goes to PARITY if the latched `PAR_EN`=1, otherwise to STOP.
- PARITY lasts 1 bit time and sends the latched parity bit, then goes to STOP.
- STOP lasts 1 bit time with `TX_OUT`=1, then goes to IDLE.
- Bit timing: a 5-bit edge counter counts 0..Prescale-1. When it reaches Prescale-1, the bit ends; the edge counter wraps to 0 and the bit counter increments.
- A latched `Prescale` below 4 is treated as 4.
- Changes to `P_DATA` or the configuration inputs during a frame have no effect, because only the shadow copies are used.
- `Data_Valid` while `busy`=1 is ignored and not queued. The requester must hold the word until it sees `busy`=0.
- Asserting reset mid-frame aborts the frame immediately: `TX_OUT`=1 and `busy`=0 asynchronously.

## Timing
- `TX_OUT` and `busy` are registered, with no combinational path from any input.
- If `Data_Valid` is sampled at edge k, `TX_OUT` goes 0 and `busy` goes 1 after edge k.
- Frame length is N = (DATA_WIDTH + 2 + PAR_EN) × Prescale cycles. `busy` falls after edge k+N, together with the end of the stop bit.
- The earliest next accept is edge k+N+1. Back-to-back frames therefore have exactly 1 idle-high cycle between the stop bit and the next start bit.
- Data bit i occupies cycles k+(1+i)·Prescale+1 through k+(2+i)·Prescale.

## Structure
- Shared package/header `uart_pkg`:
  - FSM state encoding.
  - Parity type constants: EVEN=0, ODD=1.
  - Minimum prescale constant: 4.
- The top module contains the FSM, shadow registers and output register.
- One natural sub-module, `tx_bit_timer`, holds the edge counter and bit counter. It takes an enable and the latched prescale, and outputs `bit_done` and `bit_cnt`.

## Test plan
- Even parity: `Prescale`=8, `PAR_EN`=1, `PAR_TYP`=0, `P_DATA`=8'hA5. Required `TX_OUT` bit sequence is 0,1,0,1,0,0,1,0,1,0,1, each bit held 8 cycles. `busy` is high for exactly 88 cycles.
- Odd parity: `PAR_EN`=1, `PAR_TYP`=1, `P_DATA`=8'h03. Required parity bit = 1.
- No parity: `PAR_EN`=0, `Prescale`=16, `P_DATA`=8'h00. Required frame is 10 bits (160 cycles) with no parity bit. The stop bit is high.
- Busy handling: pulse `Data_Valid` with 8'h55 mid-frame, then change `P_DATA`. The frame in flight is unchanged and no second frame is sent. Holding `Data_Valid` continuously sends back-to-back frames separated by exactly 1 idle cycle.
- Reset mid-frame: assert `RST`=0 during DATA. `TX_OUT`=1 and `busy`=0 immediately. After release, the next `Data_Valid` sends a clean full frame.
- Low prescale: `Prescale`=2. Each bit lasts 4 cycles.
